// File: rtl/fir_bist_sequencer.sv
// BIST sequencer for the FIR: LFSR stimulus, valid/ready feed, MISR compaction, golden compare.
// Optional handshake timeout is enabled with `define FIR_BIST_TIMEOUT_EN.
module fir_bist_sequencer #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NUM_VECTORS    = 64,
    parameter int unsigned SETTLE_CYCLES  = 30,
    parameter logic [31:0] SEED           = 32'h0000_0001,
    parameter logic [31:0] GOLDEN_SIG     = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [DATA_W-1:0] fir_in_data,
    output logic              fir_in_valid,
    input  logic              fir_in_ready,
    input  logic [DATA_W-1:0] fir_out_data,
    input  logic              fir_out_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [31:0]       signature,
    output logic [15:0]       vec_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [15:0] VEC_LAST    = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    function automatic logic [31:0] step(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] misr_q, misr_d;
    logic [15:0] vec_q, vec_d;
    logic [15:0] settle_q, settle_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic [DATA_W-1:0] in_word;
    logic [31:0]       out_word;
    logic              absorb;

    // Width adaptation between the 32-bit LFSR/MISR and the FIR sample width
    if (DATA_W == 32) begin : g_eq
        assign in_word  = lfsr_q;
        assign out_word = fir_out_data;
    end else if (DATA_W > 32) begin : g_wide
        assign in_word  = {{(DATA_W-32){1'b0}}, lfsr_q};
        assign out_word = fir_out_data[31:0];
    end else begin : g_narrow
        assign in_word  = lfsr_q[DATA_W-1:0];
        assign out_word = {{(32-DATA_W){1'b0}}, fir_out_data};
    end

`ifdef FIR_BIST_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_q, wait_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wait_q <= '0;
        else     wait_q <= wait_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED;
            misr_q    <= '0;
            vec_q     <= '0;
            settle_q  <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            misr_q    <= misr_d;
            vec_q     <= vec_d;
            settle_q  <= settle_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    assign absorb = fir_out_valid &&
                    (state_q == S_LOAD || state_q == S_SETTLE || state_q == S_CHECK);

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        misr_d    = misr_q;
        vec_d     = vec_q;
        settle_d  = settle_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
`ifdef FIR_BIST_TIMEOUT_EN
        wait_d    = wait_q;
`endif
        if (absorb) misr_d = step(misr_q) ^ out_word;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    lfsr_d    = SEED;
                    misr_d    = '0;
                    vec_d     = '0;
                    settle_d  = '0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
`ifdef FIR_BIST_TIMEOUT_EN
                    wait_d    = '0;
`endif
                end
            end
            S_LOAD: begin
                if (fir_in_ready) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
`ifdef FIR_BIST_TIMEOUT_EN
                    wait_d   = '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
`endif
                end
            end
            S_SETTLE: begin
                settle_d = settle_q + 16'd1;
                if (settle_q == SETTLE_LAST) begin
                    if (vec_q == VEC_LAST) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_LOAD;
                        lfsr_d  = step(lfsr_q);
                        vec_d   = vec_q + 16'd1;
                    end
                end
            end
            S_CHECK: begin
                // Compare against the signature including this cycle's absorb
                state_d = S_DONE;
                done_d  = 1'b1;
                pass_d  = (misr_d == GOLDEN_SIG);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fir_in_valid = (state_q == S_LOAD);
    assign fir_in_data  = (state_q == S_LOAD) ? in_word : '0;
    assign busy         = (state_q == S_LOAD) || (state_q == S_SETTLE) ||
                          (state_q == S_CHECK);
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;
    assign signature    = misr_q;
    assign vec_count    = vec_q;

endmodule

// File: tb/tb_fir_bist_sequencer.sv
// Directed bench: short-run timing, backpressure, resets, timeout and full-run signatures.
// FIR is modelled as a 1-cycle echo of each accepted vector.
module tb_fir_bist_sequencer;

    function automatic logic [31:0] step(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    // Echo FIR absorbs each vector exactly once, in order
    function automatic logic [31:0] model_sig(input int n);
        logic [31:0] m;
        logic [31:0] v;
        m = '0;
        v = 32'h0000_0001;
        for (int k = 0; k < n; k++) begin
            m = step(m) ^ v;
            v = step(v);
        end
        return m;
    endfunction

    localparam logic [31:0] GOLD = model_sig(64);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_a, ready_a, iv_a, ov_a;
    logic [31:0] id_a, od_a, sig_a;
    logic        busy_a, done_a, pass_a, to_a;
    logic [15:0] vec_a;

    logic        start_bc, ready_bc;
    logic        iv_b, ov_b, busy_b, done_b, pass_b, to_b;
    logic [31:0] id_b, od_b, sig_b;
    logic [15:0] vec_b;
    logic        iv_c, ov_c, busy_c, done_c, pass_c, to_c;
    logic [31:0] id_c, od_c, sig_c;
    logic [15:0] vec_c;

    fir_bist_sequencer #(
        .NUM_VECTORS(2), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(8)
    ) u_a (
        .clk(clk), .rst(rst), .start(start_a),
        .fir_in_data(id_a), .fir_in_valid(iv_a), .fir_in_ready(ready_a),
        .fir_out_data(od_a), .fir_out_valid(ov_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(to_a),
        .signature(sig_a), .vec_count(vec_a)
    );

    fir_bist_sequencer #(.GOLDEN_SIG(GOLD)) u_b (
        .clk(clk), .rst(rst), .start(start_bc),
        .fir_in_data(id_b), .fir_in_valid(iv_b), .fir_in_ready(ready_bc),
        .fir_out_data(od_b), .fir_out_valid(ov_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(to_b),
        .signature(sig_b), .vec_count(vec_b)
    );

    fir_bist_sequencer #(.GOLDEN_SIG(GOLD ^ 32'h1)) u_c (
        .clk(clk), .rst(rst), .start(start_bc),
        .fir_in_data(id_c), .fir_in_valid(iv_c), .fir_in_ready(ready_bc),
        .fir_out_data(od_c), .fir_out_valid(ov_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .timeout(to_c),
        .signature(sig_c), .vec_count(vec_c)
    );

    always @(posedge clk) begin
        ov_a <= iv_a && ready_a;
        od_a <= id_a;
        ov_b <= iv_b && ready_bc;
        od_b <= id_b;
        ov_c <= iv_c && ready_bc;
        od_c <= id_c;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic pulse_bc();
        start_bc = 1'b1;
        @(negedge clk);
        start_bc = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start_a  = 1'b0;
        start_bc = 1'b0;
        ready_a  = 1'b1;
        ready_bc = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy",  32'(busy_a), 32'd0);
        chk("rst_valid", 32'(iv_a), 32'd0);
        chk("rst_data",  id_a, 32'd0);
        chk("rst_sig",   sig_a, 32'd0);
        chk("rst_vec",   32'(vec_a), 32'd0);
        chk("rst_done",  32'(done_a), 32'd0);
        chk("rst_pass",  32'(pass_a), 32'd0);
        chk("rst_to",    32'(to_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two-vector run: vectors 0x1 then step(0x1)=0x3, sig 1 then 0
        pulse_a();
        for (int t = 1; t <= 12; t++) begin
            chk("t2_valid", 32'(iv_a), 32'(t == 1 || t == 6));
            chk("t2_busy",  32'(busy_a), 32'(t >= 1 && t <= 11));
            if (t == 1) begin
                chk("t2_data0", id_a, 32'h1);
                chk("t2_vec0",  32'(vec_a), 32'd0);
            end
            if (t == 3) chk("t2_sig1", sig_a, 32'h1);
            if (t == 6) begin
                chk("t2_data1", id_a, 32'h3);
                chk("t2_vec1",  32'(vec_a), 32'd1);
            end
            if (t == 11) chk("t2_chk_done", 32'(done_a), 32'd0);
            if (t == 12) begin
                chk("t2_done", 32'(done_a), 32'd1);
                chk("t2_pass", 32'(pass_a), 32'd1);
                chk("t2_sig",  sig_a, 32'h0);
            end
            @(negedge clk);
        end
        chk("t2_frozen", 32'(done_a), 32'd1);

        // Restart from DONE, then async reset mid-cycle during SETTLE
        pulse_a();
        chk("rs_done_clr", 32'(done_a), 32'd0);
        chk("rs_data", id_a, 32'h1);
        repeat (2) @(negedge clk);
        chk("rs_sig_pre", sig_a, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rs_busy",  32'(busy_a), 32'd0);
        chk("rs_sig",   sig_a, 32'd0);
        chk("rs_vec",   32'(vec_a), 32'd0);
        chk("rs_valid", 32'(iv_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rs_idle", 32'(busy_a), 32'd0);

        // Backpressure: 5 stalled LOAD cycles, transfer on the 6th
        ready_a = 1'b0;
        pulse_a();
        for (int t = 1; t <= 5; t++) begin
            chk("bp_valid", 32'(iv_a), 32'd1);
            chk("bp_data",  id_a, 32'h1);
            chk("bp_vec",   32'(vec_a), 32'd0);
            @(negedge clk);
        end
        chk("bp_valid6", 32'(iv_a), 32'd1);
        ready_a = 1'b1;
        @(negedge clk);
        chk("bp_settle_valid", 32'(iv_a), 32'd0);
        chk("bp_settle_busy",  32'(busy_a), 32'd1);
        chk("bp_settle_vec",   32'(vec_a), 32'd0);
        for (int i = 0; i < 100 && !done_a; i++) @(negedge clk);
        chk("bp_done", 32'(done_a), 32'd1);
        chk("bp_pass", 32'(pass_a), 32'd1);
        chk("bp_to",   32'(to_a), 32'd0);

        // Permanent stall on the first vector
        ready_a = 1'b0;
        pulse_a();
        for (int t = 1; t <= 8; t++) begin
            chk("to_valid", 32'(iv_a), 32'd1);
            @(negedge clk);
        end
`ifdef FIR_BIST_TIMEOUT_EN
        chk("to_done",  32'(done_a), 32'd1);
        chk("to_flag",  32'(to_a), 32'd1);
        chk("to_pass",  32'(pass_a), 32'd0);
        chk("to_drop",  32'(iv_a), 32'd0);
        chk("to_busy",  32'(busy_a), 32'd0);
`else
        chk("to_done",  32'(done_a), 32'd0);
        chk("to_flag",  32'(to_a), 32'd0);
        chk("to_hold",  32'(iv_a), 32'd1);
        repeat (20) @(negedge clk);
        chk("to_hold2", 32'(iv_a), 32'd1);
        chk("to_flag2", 32'(to_a), 32'd0);
`endif
        ready_a = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full default run against echo FIR; B golden matches, C off by one bit
        pulse_bc();
        for (int i = 0; i < 3000 && !done_b; i++) @(negedge clk);
        chk("fr_done",   32'(done_b), 32'd1);
        chk("fr_pass_b", 32'(pass_b), 32'd1);
        chk("fr_sig_b",  sig_b, GOLD);
        chk("fr_vec_b",  32'(vec_b), 32'd63);
        chk("fr_busy_b", 32'(busy_b), 32'd0);
        chk("fr_to_b",   32'(to_b), 32'd0);
        chk("fr_done_c", 32'(done_c), 32'd1);
        chk("fr_pass_c", 32'(pass_c), 32'd0);
        chk("fr_sig_c",  sig_c, GOLD);
        chk("fr_busy_c", 32'(busy_c), 32'd0);
        chk("fr_vec_c",  32'(vec_c), 32'd63);
        chk("fr_to_c",   32'(to_c), 32'd0);

        // Reset during SETTLE of vector 10, then rerun
        pulse_bc();
        for (int i = 0; i < 1000 && vec_b != 16'd10; i++) @(negedge clk);
        for (int i = 0; i < 10 && iv_b; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("mr_vec_pre",  32'(vec_b), 32'd10);
        chk("mr_busy_pre", 32'(busy_b), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mr_vec",  32'(vec_b), 32'd0);
        chk("mr_busy", 32'(busy_b), 32'd0);
        chk("mr_sig",  sig_b, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_bc();
        for (int i = 0; i < 3000 && !done_b; i++) @(negedge clk);
        chk("mr_done", 32'(done_b), 32'd1);
        chk("mr_sig2", sig_b, GOLD);
        chk("mr_pass", 32'(pass_b), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
